univ_reg: RTL and testbench
===========================

Name: univ_reg

Overview:
- Parametrised universal register, the successor to the 16-bit loadable register.
- Besides load/hold, it performs shift, rotate, and up/down count in one cycle.
- Count and shift paths raise a carry/shift-out pulse and a sticky overflow flag.
- Used as an operand/accumulator register, an address counter, or a serial converter in datapath labs.

Parameters:
- WIDTH, 16: data width in bits (min 2).
- RESET_VAL, 0: value of Q after reset; truncated to WIDTH.
- SATURATE, 0: 1 = counts clamp at all-ones/zero; 0 = counts wrap.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear; highest priority after reset.
- mode  in  3  operation select (encoding below).
- D  in  WIDTH  parallel load data.
- sin  in  1  serial-in bit for shifts.
- Q  out  WIDTH  registered value.
- cout  out  1  registered one-cycle pulse: carry/borrow on count, or bit shifted out on shift.
- ovf  out  1  sticky overflow: set on count wrap/clamp event; cleared by load, clr or reset.
- zero  out  1  combinational, (Q == 0).

Behaviour:
- Reset (reset_n low, async):
  - Q = RESET_VAL, cout = 0, ovf = 0, asserted immediately without waiting for clk.
  - Deassertion takes effect at the next rising edge.
- Priority per rising edge: clr > mode.
  - clr=1 gives Q=0, cout=0, ovf=0, regardless of mode.
- Mode encoding (all results visible on Q one cycle after the edge; latency 1):
  - 000 HOLD: Q unchanged, cout=0.
  - 001 LOAD: Q=D, cout=0, ovf=0.
  - 010 SHL: Q={Q[W-2:0],sin}, cout=Q[W-1].
  - 011 SHR: Q={sin,Q[W-1:1]}, cout=Q[0].
  - 100 ROL: Q={Q[W-2:0],Q[W-1]}, cout=Q[W-1].
  - 101 ROR: Q={Q[0],Q[W-1:1]}, cout=Q[0].
  - 110 INC: Q=Q+1 (WIDTH-bit).
    - At Q=all-ones: SATURATE=0 gives Q=0, cout=1, ovf set; SATURATE=1 gives Q holds all-ones, cout=0, ovf set.
  - 111 DEC: Q=Q-1.
    - At Q=0: SATURATE=0 gives Q=all-ones, cout=1 (borrow), ovf set; SATURATE=1 gives Q holds 0, cout=0, ovf set.
- Flag rules:
  - cout is 0 in every cycle that is not a shift, rotate or count-wrap. It never stays high beyond one cycle unless the event repeats.
  - ovf stays set through HOLD/shift/rotate/count. Only LOAD, clr or reset clear it.
  - ovf is never set by shifts or rotates.
  - zero follows Q combinationally, so it is valid the same cycle Q updates.
- The state machine is implicit: the register value is the state, and mode selects the next-state function. No multi-cycle operations and no handshake.
- Unknown/X on mode is not legal. A simulation assertion flags it; RTL treats it as HOLD via the default branch.

Decomposition:
- Shared package univ_reg_pkg holds:
  - MODE_W = 3;
  - localparams MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_INC, MODE_DEC;
  - a typedef for the mode enum.
- One natural sub-module: univ_reg_next.
  - Purely combinational next-state/flag function: inputs Q, D, sin, mode, SATURATE; outputs q_next, cout_next, ovf_set, ovf_clr.
  - The top holds only the flops, the clr priority and the sticky-ovf logic.

Test Plan (WIDTH=16, RESET_VAL=0 unless stated):
- Async reset: drive mode=LOAD, D=16'hBEEF, clock, then pull reset_n low mid-cycle. Q=0, cout=0, ovf=0 before the next edge. With RESET_VAL=16'h00FF, Q=16'h00FF.
- Load/hold: LOAD D=16'h1234, then 3 cycles HOLD. Q=16'h1234 throughout, cout=0, zero=0.
- Shift/rotate: load 16'h8001.
  - SHL sin=0 gives Q=16'h0002, cout=1.
  - Reload, ROR gives Q=16'hC000, cout=1.
  - Reload, SHR sin=1 gives Q=16'hC000, cout=1.
- Count wrap (SATURATE=0):
  - Load 16'hFFFE, INC x2 gives 16'hFFFF (cout=0) then 16'h0000 (cout=1 for one cycle, ovf=1, zero=1).
  - HOLD keeps ovf=1; LOAD 16'h0005 clears ovf.
- Count saturate (SATURATE=1): load 16'h0001, DEC x3 gives 0, 0, 0; ovf=1 from the second DEC; cout=0 always.
- clr priority: mode=INC with clr=1 at Q=16'h00AA and ovf=1 gives Q=0, ovf=0, cout=0 next cycle.

Source files
------------

// File: rtl/univ_reg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | univ_reg_pkg : shared mode encoding for the universal register             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package univ_reg_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
    localparam logic [MODE_W-1:0] MODE_INC  = 3'b110;
    localparam logic [MODE_W-1:0] MODE_DEC  = 3'b111;

    typedef enum logic [MODE_W-1:0] {
        M_HOLD = MODE_HOLD,
        M_LOAD = MODE_LOAD,
        M_SHL  = MODE_SHL,
        M_SHR  = MODE_SHR,
        M_ROL  = MODE_ROL,
        M_ROR  = MODE_ROR,
        M_INC  = MODE_INC,
        M_DEC  = MODE_DEC
    } mode_e;

endpackage
`default_nettype wire

// File: rtl/univ_reg_next.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | univ_reg_next : combinational next-value and flag function                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module univ_reg_next
    import univ_reg_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_sin,
    input  mode_e            i_mode,
    output logic [WIDTH-1:0] o_q_next,
    output logic             o_cout_next,
    output logic             o_ovf_set,
    output logic             o_ovf_clr
);

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    always_comb begin
        o_q_next    = i_q;
        o_cout_next = 1'b0;
        o_ovf_set   = 1'b0;
        o_ovf_clr   = 1'b0;
        case (i_mode)
            M_LOAD: begin
                o_q_next  = i_d;
                o_ovf_clr = 1'b1;
            end
            M_SHL: begin
                o_q_next    = {i_q[WIDTH-2:0], i_sin};
                o_cout_next = i_q[WIDTH-1];
            end
            M_SHR: begin
                o_q_next    = {i_sin, i_q[WIDTH-1:1]};
                o_cout_next = i_q[0];
            end
            M_ROL: begin
                o_q_next    = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
                o_cout_next = i_q[WIDTH-1];
            end
            M_ROR: begin
                o_q_next    = {i_q[0], i_q[WIDTH-1:1]};
                o_cout_next = i_q[0];
            end
            M_INC: begin
                // Saturating counts flag the clamp in ovf only; cout marks a real wrap.
                if (&i_q) begin
                    o_ovf_set = 1'b1;
                    if (SATURATE == 0) begin
                        o_q_next    = '0;
                        o_cout_next = 1'b1;
                    end
                end else begin
                    o_q_next = i_q + C_ONE;
                end
            end
            M_DEC: begin
                if (i_q == '0) begin
                    o_ovf_set = 1'b1;
                    if (SATURATE == 0) begin
                        o_q_next    = '1;
                        o_cout_next = 1'b1;
                    end
                end else begin
                    o_q_next = i_q - C_ONE;
                end
            end
            default: begin
                o_q_next = i_q;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/univ_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | univ_reg : universal register - load, shift, rotate, up/down count         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module univ_reg
    import univ_reg_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter     RESET_VAL = 0,
    parameter int SATURATE  = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  D,
    input  logic              sin,
    output logic [WIDTH-1:0]  Q,
    output logic              cout,
    output logic              ovf,
    output logic              zero
);

    localparam logic [WIDTH-1:0] C_RESET_Q = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] q_q, q_d, w_q_next;
    logic             cout_q, cout_d, w_cout_next;
    logic             ovf_q, ovf_d, w_ovf_set, w_ovf_clr;
    mode_e            w_mode;

    assign w_mode = mode_e'(mode);

    univ_reg_next #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_next (
        .i_q         (q_q),
        .i_d         (D),
        .i_sin       (sin),
        .i_mode      (w_mode),
        .o_q_next    (w_q_next),
        .o_cout_next (w_cout_next),
        .o_ovf_set   (w_ovf_set),
        .o_ovf_clr   (w_ovf_clr)
    );

    always_comb begin
        q_d    = w_q_next;
        cout_d = w_cout_next;
        ovf_d  = w_ovf_clr ? 1'b0 : (ovf_q | w_ovf_set);
        if (clr) begin
            q_d    = '0;
            cout_d = 1'b0;
            ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q    <= C_RESET_Q;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign Q    = q_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = (q_q == '0);

    // An unknown mode would silently act as HOLD in hardware; catch it in simulation.
    always @(posedge clk) begin
        if (reset_n) begin
            assert (!$isunknown(mode));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_univ_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_univ_reg : directed self-checking bench for univ_reg                     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_univ_reg;
    import univ_reg_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clr;
    logic [2:0]  mode;
    logic [15:0] D;
    logic        sin;

    logic [15:0] Q, Q_sat, Q_rv;
    logic        cout, cout_sat, cout_rv;
    logic        ovf, ovf_sat, ovf_rv;
    logic        zero, zero_sat, zero_rv;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    univ_reg #(.WIDTH(16), .RESET_VAL(0), .SATURATE(0)) dut (
        .clk(clk), .reset_n(reset_n), .clr(clr), .mode(mode), .D(D), .sin(sin),
        .Q(Q), .cout(cout), .ovf(ovf), .zero(zero)
    );

    univ_reg #(.WIDTH(16), .RESET_VAL(0), .SATURATE(1)) dut_sat (
        .clk(clk), .reset_n(reset_n), .clr(clr), .mode(mode), .D(D), .sin(sin),
        .Q(Q_sat), .cout(cout_sat), .ovf(ovf_sat), .zero(zero_sat)
    );

    univ_reg #(.WIDTH(16), .RESET_VAL(16'h00FF), .SATURATE(0)) dut_rv (
        .clk(clk), .reset_n(reset_n), .clr(clr), .mode(mode), .D(D), .sin(sin),
        .Q(Q_rv), .cout(cout_rv), .ovf(ovf_rv), .zero(zero_rv)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; clr = 1'b0; mode = MODE_HOLD; D = 16'h0000; sin = 1'b0;
        tick();
        n_checks++;
        if (Q !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0 || zero !== 1'b1)
            $display("FAIL reset_state: Q=%h cout=%b ovf=%b zero=%b, want 0000/0/0/1", Q, cout, ovf, zero);
        else n_pass++;
        n_checks++;
        if (Q_rv !== 16'h00FF || zero_rv !== 1'b0)
            $display("FAIL reset_val: Q=%h zero=%b, want 00ff/0", Q_rv, zero_rv);
        else n_pass++;
        reset_n = 1'b1;
        mode = MODE_LOAD; D = 16'hBEEF;
        tick();
        n_checks++;
        if (Q !== 16'hBEEF || Q_rv !== 16'hBEEF)
            $display("FAIL reset_load: Q=%h Q_rv=%h, want beef", Q, Q_rv);
        else n_pass++;
        mode = MODE_INC; D = 16'hFFFF;
        tick();
        mode = MODE_HOLD;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (Q !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0 || Q_rv !== 16'h00FF)
            $display("FAIL async_reset: Q=%h cout=%b ovf=%b Q_rv=%h, want 0000/0/0/00ff", Q, cout, ovf, Q_rv);
        else n_pass++;
        #2;
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (Q !== 16'h0000 || Q_rv !== 16'h00FF)
            $display("FAIL reset_release: Q=%h Q_rv=%h, want 0000/00ff", Q, Q_rv);
        else n_pass++;
    endtask

    task automatic test_load_hold();
        mode = MODE_LOAD; D = 16'h1234;
        tick();
        n_checks++;
        if (Q !== 16'h1234 || cout !== 1'b0 || zero !== 1'b0)
            $display("FAIL load: Q=%h cout=%b zero=%b, want 1234/0/0", Q, cout, zero);
        else n_pass++;
        mode = MODE_HOLD; D = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (Q !== 16'h1234 || cout !== 1'b0 || zero !== 1'b0)
                $display("FAIL hold%0d: Q=%h cout=%b zero=%b, want 1234/0/0", i, Q, cout, zero);
            else n_pass++;
        end
    endtask

    task automatic test_shift_rotate();
        logic [2:0]  modes [4];
        logic        sins  [4];
        logic [15:0] exp_q [4];
        modes = '{MODE_SHL, MODE_ROR, MODE_SHR, MODE_ROL};
        sins  = '{1'b0, 1'b0, 1'b1, 1'b0};
        exp_q = '{16'h0002, 16'hC000, 16'hC000, 16'h0003};
        for (int i = 0; i < 4; i++) begin
            mode = MODE_LOAD; D = 16'h8001;
            tick();
            mode = modes[i]; sin = sins[i];
            tick();
            n_checks++;
            if (Q !== exp_q[i] || cout !== 1'b1 || ovf !== 1'b0)
                $display("FAIL shift%0d: Q=%h cout=%b ovf=%b, want %h/1/0", i, Q, cout, ovf, exp_q[i]);
            else n_pass++;
        end
        mode = MODE_SHR; sin = 1'b0;
        tick();
        n_checks++;
        if (Q !== 16'h0001 || cout !== 1'b1)
            $display("FAIL shr_cout: Q=%h cout=%b, want 0001/1", Q, cout);
        else n_pass++;
        mode = MODE_SHL;
        tick();
        n_checks++;
        if (Q !== 16'h0002 || cout !== 1'b0)
            $display("FAIL shl_nocout: Q=%h cout=%b, want 0002/0", Q, cout);
        else n_pass++;
    endtask

    task automatic test_count_wrap();
        mode = MODE_LOAD; D = 16'hFFFE;
        tick();
        mode = MODE_INC;
        tick();
        n_checks++;
        if (Q !== 16'hFFFF || cout !== 1'b0 || ovf !== 1'b0)
            $display("FAIL inc1: Q=%h cout=%b ovf=%b, want ffff/0/0", Q, cout, ovf);
        else n_pass++;
        tick();
        n_checks++;
        if (Q !== 16'h0000 || cout !== 1'b1 || ovf !== 1'b1 || zero !== 1'b1)
            $display("FAIL inc_wrap: Q=%h cout=%b ovf=%b zero=%b, want 0000/1/1/1", Q, cout, ovf, zero);
        else n_pass++;
        n_checks++;
        if (Q_sat !== 16'hFFFF || cout_sat !== 1'b0 || ovf_sat !== 1'b1)
            $display("FAIL inc_sat: Q=%h cout=%b ovf=%b, want ffff/0/1", Q_sat, cout_sat, ovf_sat);
        else n_pass++;
        mode = MODE_HOLD;
        tick();
        n_checks++;
        if (Q !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b1)
            $display("FAIL hold_ovf: Q=%h cout=%b ovf=%b, want 0000/0/1", Q, cout, ovf);
        else n_pass++;
        mode = MODE_LOAD; D = 16'h0005;
        tick();
        n_checks++;
        if (Q !== 16'h0005 || ovf !== 1'b0 || zero !== 1'b0)
            $display("FAIL load_clr_ovf: Q=%h ovf=%b zero=%b, want 0005/0/0", Q, ovf, zero);
        else n_pass++;
        mode = MODE_DEC;
        tick();
        n_checks++;
        if (Q !== 16'h0004 || cout !== 1'b0 || ovf !== 1'b0)
            $display("FAIL dec: Q=%h cout=%b ovf=%b, want 0004/0/0", Q, cout, ovf);
        else n_pass++;
        mode = MODE_LOAD; D = 16'h0000;
        tick();
        mode = MODE_DEC;
        tick();
        n_checks++;
        if (Q !== 16'hFFFF || cout !== 1'b1 || ovf !== 1'b1)
            $display("FAIL dec_wrap: Q=%h cout=%b ovf=%b, want ffff/1/1", Q, cout, ovf);
        else n_pass++;
    endtask

    task automatic test_saturate();
        mode = MODE_LOAD; D = 16'h0001;
        tick();
        mode = MODE_DEC;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (Q_sat !== 16'h0000 || cout_sat !== 1'b0 || ovf_sat !== (i != 0) || zero_sat !== 1'b1)
                $display("FAIL sat_dec%0d: Q=%h cout=%b ovf=%b zero=%b, want 0000/0/%b/1",
                         i, Q_sat, cout_sat, ovf_sat, zero_sat, (i != 0));
            else n_pass++;
        end
    endtask

    task automatic test_clr_priority();
        logic [7:0] pattern;
        mode = MODE_LOAD; D = 16'hFFFF;
        tick();
        mode = MODE_INC;
        tick();
        pattern = 8'hAA;
        mode = MODE_SHL;
        for (int i = 7; i >= 0; i--) begin
            sin = pattern[i];
            tick();
        end
        n_checks++;
        if (Q !== 16'h00AA || ovf !== 1'b1)
            $display("FAIL pre_clr: Q=%h ovf=%b, want 00aa/1", Q, ovf);
        else n_pass++;
        mode = MODE_INC; clr = 1'b1;
        tick();
        clr = 1'b0; mode = MODE_HOLD;
        n_checks++;
        if (Q !== 16'h0000 || ovf !== 1'b0 || cout !== 1'b0 || zero !== 1'b1)
            $display("FAIL clr: Q=%h ovf=%b cout=%b zero=%b, want 0000/0/0/1", Q, ovf, cout, zero);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  modes [5];
        logic [15:0] exp_q [5];
        logic        exp_c [5];
        modes = '{MODE_INC, MODE_INC, MODE_SHL, MODE_DEC, MODE_ROR};
        exp_q = '{16'h0001, 16'h0002, 16'h0004, 16'h0003, 16'h8001};
        exp_c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        sin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mode = modes[i];
            tick();
            n_checks++;
            if (Q !== exp_q[i] || cout !== exp_c[i])
                $display("FAIL b2b%0d: Q=%h cout=%b, want %h/%b", i, Q, cout, exp_q[i], exp_c[i]);
            else n_pass++;
        end
        mode = MODE_HOLD;
    endtask

    initial begin
        test_reset();
        test_load_hold();
        test_shift_rotate();
        test_count_wrap();
        test_saturate();
        test_clr_priority();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
